// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory request arbiter and its
// outstanding-request tables.
package mem_arb_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int MAX_OUT_DEF = 8;
  localparam int ID_W_DEF    = id_width(NUM_REQ_DEF);

  // Lifecycle of one outstanding-table slot.
  typedef enum logic {
    ENT_FREE    = 1'b0,
    ENT_PENDING = 1'b1
  } ent_state_t;

  // Logical content of one table slot at default widths.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [ID_W_DEF-1:0]   req_id;
  } tbl_entry_t;

endpackage

// File: rtl/outstanding_table.sv
// CAM of in-flight requests for one direction. Allocates a free slot on
// grant, frees the slot whose address matches a returned ack, and reports
// address hazards for every requester's current address.
module outstanding_table
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int NUM_Q   = NUM_REQ_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_en,
  input  logic [ADDR_W-1:0]       alloc_addr,
  input  logic [ID_W-1:0]         alloc_id,
  input  logic                    ret_en,
  input  logic [ADDR_W-1:0]       ret_addr,
  output logic                    ret_hit,
  output logic [ID_W-1:0]         ret_id,
  input  logic [NUM_Q*ADDR_W-1:0] hz_addr,
  output logic [NUM_Q-1:0]        hz_match,
  output logic                    full
);

  ent_state_t        r_state     [MAX_OUT];
  ent_state_t        w_state_nxt [MAX_OUT];
  logic [ADDR_W-1:0] r_addr      [MAX_OUT];
  logic [ID_W-1:0]   r_id        [MAX_OUT];
  logic [MAX_OUT-1:0] w_pend;
  logic [MAX_OUT-1:0] w_alloc_vec;
  logic [MAX_OUT-1:0] w_ret_vec;
  logic               w_found;

  // Decode which slots currently hold an in-flight request.
  always_comb begin
    for (int e = 0; e < MAX_OUT; e++) begin
      w_pend[e] = (r_state[e] == ENT_PENDING);
    end
  end

  assign full = &w_pend;

  // Pick the lowest-numbered free slot for a new grant.
  always_comb begin
    w_alloc_vec = '0;
    w_found     = 1'b0;
    for (int e = 0; e < MAX_OUT; e++) begin
      if (!w_found && !w_pend[e]) begin
        w_alloc_vec[e] = alloc_en;
        w_found        = 1'b1;
      end
    end
  end

  // Match a returned ack against in-flight addresses; at most one can hit
  // because the arbiter never lets two in-flight entries share an address.
  always_comb begin
    ret_id = '0;
    for (int e = 0; e < MAX_OUT; e++) begin
      w_ret_vec[e] = ret_en && w_pend[e] && (r_addr[e] == ret_addr);
      if (w_ret_vec[e]) begin
        ret_id = r_id[e];
      end
    end
    ret_hit = |w_ret_vec;
  end

  // Hazard lookup of every requester's address against in-flight entries.
  always_comb begin
    hz_match = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      for (int e = 0; e < MAX_OUT; e++) begin
        if (w_pend[e] && (r_addr[e] == hz_addr[q*ADDR_W +: ADDR_W])) begin
          hz_match[q] = 1'b1;
        end
      end
    end
  end

  // Per-slot next state: FREE -> PENDING on allocation, PENDING -> FREE on return.
  always_comb begin
    for (int e = 0; e < MAX_OUT; e++) begin
      w_state_nxt[e] = r_state[e];
      case (r_state[e])
        ENT_FREE:    if (w_alloc_vec[e]) w_state_nxt[e] = ENT_PENDING;
        ENT_PENDING: if (w_ret_vec[e])   w_state_nxt[e] = ENT_FREE;
        default:     w_state_nxt[e] = ENT_FREE;
      endcase
    end
  end

  // Slot state register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    for (int e = 0; e < MAX_OUT; e++) begin
      if (rst) begin
        r_state[e] <= ENT_FREE;
      end else begin
        r_state[e] <= w_state_nxt[e];
      end
    end
  end

  // Capture address and owner of a newly allocated slot.
  always_ff @(posedge clk) begin
    for (int e = 0; e < MAX_OUT; e++) begin
      if (w_alloc_vec[e]) begin
        r_addr[e] <= alloc_addr;
        r_id[e]   <= alloc_id;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the memory controller read and write ports among NUM_REQ
// requesters: round-robin grant per direction, per-address ordering via
// two outstanding tables, and routing of returns back to the issuer.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rd_resp_valid,
  output logic [ADDR_W-1:0]         rd_resp_addr,
  output logic [DATA_W-1:0]         rd_resp_data,
  output logic [NUM_REQ-1:0]        wr_resp_valid,
  output logic [ADDR_W-1:0]         wr_resp_addr,
  output logic                      err_unmatched,
  output logic [ADDR_W-1:0]         mc_wr_address,
  output logic                      mc_wr_en,
  output logic [DATA_W-1:0]         mc_wr_data,
  input  logic [ADDR_W-1:0]         mc_wr_ret_address,
  input  logic                      mc_wr_ret_ack,
  output logic [ADDR_W-1:0]         mc_rd_address,
  output logic                      mc_rd_en,
  input  logic [DATA_W-1:0]         mc_rd_ret_data,
  input  logic [ADDR_W-1:0]         mc_rd_ret_address,
  input  logic                      mc_rd_ret_ack
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [DATA_W-1:0]  w_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_rd_hz_rd, w_rd_hz_wr;
  logic               w_rd_full, w_wr_full;
  logic [NUM_REQ-1:0] w_rd_elig, w_wr_elig;
  logic [ID_W:0]      w_rd_pick, w_wr_pick;
  logic               w_rd_gnt, w_wr_gnt;
  logic [ID_W-1:0]    w_rd_idx, w_wr_idx;
  logic [ADDR_W-1:0]  w_rd_gnt_addr, w_wr_gnt_addr;
  logic [DATA_W-1:0]  w_wr_gnt_data;
  logic               w_rd_ret_hit, w_wr_ret_hit;
  logic [ID_W-1:0]    w_rd_ret_id, w_wr_ret_id;
  logic [ID_W-1:0]    r_rd_ptr, r_wr_ptr;
  logic               r_err;

  // First eligible index at or after ptr, as {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            best_d;
    int            d;
    res    = '0;
    best_d = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i - int'(ptr) + NUM_REQ) % NUM_REQ;
      if (elig[i] && (d < best_d)) begin
        best_d = d;
        res    = {1'b1, ID_W'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
    if (idx == ID_W'(NUM_REQ - 1)) return '0;
    return idx + ID_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Unpack the per-requester address and data buses.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
      w_data[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  outstanding_table #(
    .MAX_OUT (MAX_OUT),
    .ADDR_W  (ADDR_W),
    .ID_W    (ID_W),
    .NUM_Q   (NUM_REQ)
  ) u_rd_table (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (w_rd_gnt),
    .alloc_addr (w_rd_gnt_addr),
    .alloc_id   (w_rd_idx),
    .ret_en     (mc_rd_ret_ack),
    .ret_addr   (mc_rd_ret_address),
    .ret_hit    (w_rd_ret_hit),
    .ret_id     (w_rd_ret_id),
    .hz_addr    (req_addr),
    .hz_match   (w_rd_hz_rd),
    .full       (w_rd_full)
  );

  outstanding_table #(
    .MAX_OUT (MAX_OUT),
    .ADDR_W  (ADDR_W),
    .ID_W    (ID_W),
    .NUM_Q   (NUM_REQ)
  ) u_wr_table (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (w_wr_gnt),
    .alloc_addr (w_wr_gnt_addr),
    .alloc_id   (w_wr_idx),
    .ret_en     (mc_wr_ret_ack),
    .ret_addr   (mc_wr_ret_address),
    .ret_hit    (w_wr_ret_hit),
    .ret_id     (w_wr_ret_id),
    .hz_addr    (req_addr),
    .hz_match   (w_rd_hz_wr),
    .full       (w_wr_full)
  );

  // Write eligibility: any in-flight access to the address blocks a write.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_wr_elig[i] = req_valid[i] & req_we[i] & ~w_wr_full & ~w_rd_hz_rd[i] & ~w_rd_hz_wr[i];
    end
  end

  assign w_wr_pick     = rr_pick(w_wr_elig, r_wr_ptr);
  assign w_wr_gnt      = w_wr_pick[ID_W];
  assign w_wr_idx      = w_wr_pick[ID_W-1:0];
  assign w_wr_gnt_addr = w_addr[w_wr_idx];
  assign w_wr_gnt_data = w_data[w_wr_idx];

  // Read eligibility: also yields to a write granted this cycle to the same address.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rd_elig[i] = req_valid[i] & ~req_we[i] & ~w_rd_full & ~w_rd_hz_rd[i] & ~w_rd_hz_wr[i]
                     & ~(w_wr_gnt && (w_addr[i] == w_wr_gnt_addr));
    end
  end

  assign w_rd_pick     = rr_pick(w_rd_elig, r_rd_ptr);
  assign w_rd_gnt      = w_rd_pick[ID_W];
  assign w_rd_idx      = w_rd_pick[ID_W-1:0];
  assign w_rd_gnt_addr = w_addr[w_rd_idx];

  // One-hot grant per direction, merged onto the shared ready vector.
  always_comb begin
    req_ready = '0;
    if (w_rd_gnt) req_ready = req_ready | id_onehot(w_rd_idx);
    if (w_wr_gnt) req_ready = req_ready | id_onehot(w_wr_idx);
  end

  // Round-robin pointers advance past the winner and hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_rd_gnt) r_rd_ptr <= ptr_after(w_rd_idx);
      if (w_wr_gnt) r_wr_ptr <= ptr_after(w_wr_idx);
    end
  end

  // Issue registers toward the memory controller, one cycle after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_rd_en      <= 1'b0;
      mc_rd_address <= '0;
      mc_wr_en      <= 1'b0;
      mc_wr_address <= '0;
      mc_wr_data    <= '0;
    end else begin
      mc_rd_en <= w_rd_gnt;
      mc_wr_en <= w_wr_gnt;
      if (w_rd_gnt) mc_rd_address <= w_rd_gnt_addr;
      if (w_wr_gnt) begin
        mc_wr_address <= w_wr_gnt_addr;
        mc_wr_data    <= w_wr_gnt_data;
      end
    end
  end

  // Return routing to the issuing requester; unmatched returns latch the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_resp_valid <= '0;
      rd_resp_addr  <= '0;
      rd_resp_data  <= '0;
      wr_resp_valid <= '0;
      wr_resp_addr  <= '0;
      r_err         <= 1'b0;
    end else begin
      rd_resp_valid <= w_rd_ret_hit ? id_onehot(w_rd_ret_id) : '0;
      wr_resp_valid <= w_wr_ret_hit ? id_onehot(w_wr_ret_id) : '0;
      if (w_rd_ret_hit) begin
        rd_resp_addr <= mc_rd_ret_address;
        rd_resp_data <= mc_rd_ret_data;
      end
      if (w_wr_ret_hit) begin
        wr_resp_addr <= mc_wr_ret_address;
      end
      r_err <= r_err | (mc_rd_ret_ack & ~w_rd_ret_hit) | (mc_wr_ret_ack & ~w_wr_ret_hit);
    end
  end

  assign err_unmatched = r_err;

endmodule
